// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
// Entries are stored at fixed maximum widths so the struct can live in the package.
package fwd_pkg;

  localparam int FWD_AW_MAX = 8;
  localparam int FWD_RDY_W  = 4;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [FWD_AW_MAX-1:0] rd;
    logic [FWD_RDY_W-1:0]  ready;
  } fwd_entry_t;

  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority search of the in-flight writers for one source operand.
// The youngest matching writer decides: forward if ready, otherwise hazard.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W  = fwd_sel_w(DEPTH)
) (
  input  logic              req,
  input  logic [REG_AW-1:0] rs,
  input  fwd_entry_t        stages [DEPTH],
  output logic              hit,
  output logic [SEL_W-1:0]  sel,
  output logic              hazard
);

  logic [FWD_AW_MAX-1:0] rs_ext;

  assign rs_ext = FWD_AW_MAX'(rs);

  always_comb begin
    hit    = 1'b0;
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      // Once a younger entry has matched, older ones are ignored even if ready.
      if (!hit && req && (rs_ext != '0) && stages[k].valid && stages[k].we &&
          (stages[k].rd == rs_ext)) begin
        hit = 1'b1;
        if ((k + FWD_EXMEM) >= int'(stages[k].ready))
          sel = SEL_W'(k + FWD_EXMEM);
        else
          hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the instruction in ID.
// Tracks DEPTH in-flight writers; selects are registered into EX with the instruction.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int REG_AW  = 5,
  parameter int SEL_W   = fwd_sel_w(DEPTH)
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       ID_Valid,
  input  logic [NUM_SRC*REG_AW-1:0]  ID_Rs,
  input  logic [NUM_SRC-1:0]         ID_Src_Used,
  input  logic                       ID_Reg_Write,
  input  logic [REG_AW-1:0]          ID_Rd,
  input  logic [SEL_W-1:0]           ID_Ready_Stage,
  input  logic                       Flush,
  output logic                       Stall,
  output logic [NUM_SRC*SEL_W-1:0]   F_Mux_Ctr,
  output logic [31:0]                Stall_Count
);

  fwd_entry_t                 s_q [DEPTH];
  logic [NUM_SRC-1:0]         hit;
  logic [NUM_SRC-1:0]         hazard;
  logic [NUM_SRC*SEL_W-1:0]   sel_fwd;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [SEL_W-1:0] sel_raw;

    fwd_src_match #(
      .DEPTH  (DEPTH),
      .REG_AW (REG_AW),
      .SEL_W  (SEL_W)
    ) u_match (
      .req    (ID_Valid & ID_Src_Used[i]),
      .rs     (ID_Rs[i*REG_AW +: REG_AW]),
      .stages (s_q),
      .hit    (hit[i]),
      .sel    (sel_raw),
      .hazard (hazard[i])
    );

    assign sel_fwd[i*SEL_W +: SEL_W] = (hit[i] && !hazard[i]) ? sel_raw : '0;
  end

  assign Stall = ID_Valid & ~Flush & (|hazard);

  // ID -> EX boundary: shift tracked writers, register selects, count stalls.
  // Only valid bits are reset; rd/we/ready are don't-care while invalid.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) s_q[k].valid <= 1'b0;
      F_Mux_Ctr   <= '0;
      Stall_Count <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        s_q[k] <= s_q[k-1];
        if (k == 1 && Flush) s_q[k].valid <= 1'b0;
      end
      s_q[0].valid <= ID_Valid & ~Stall & ~Flush;
      s_q[0].we    <= ID_Reg_Write;
      s_q[0].rd    <= FWD_AW_MAX'(ID_Rd);
      s_q[0].ready <= FWD_RDY_W'(ID_Ready_Stage);
      F_Mux_Ctr    <= (Stall | Flush) ? '0 : sel_fwd;
      Stall_Count  <= Stall_Count + 32'(Stall);
    end
  end

endmodule
